// File: rtl/fetch_issue_unit.sv
// rtl/fetch_issue_unit.sv - instruction fetch and issue stage with boot vector, immediate assembly and redirect
module fetch_issue_unit #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned BOOT_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              if_valid,
  output logic [4:0]        if_opcode,
  output logic [2:0]        if_rdst,
  output logic [2:0]        if_rsrc1,
  output logic [2:0]        if_rsrc2,
  output logic              if_has_imm,
  output logic [15:0]       if_imm,
  output logic [ADDR_W-1:0] if_pc
);

  typedef enum logic [1:0] {BOOT, FETCH, FETCH_IMM} state_t;

  localparam logic [ADDR_W-1:0] BOOT_A = ADDR_W'(BOOT_ADDR);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] boot_pc;

  // First word of a two-word instruction waits here for its immediate
  logic [4:0]        hold_opcode_q, hold_opcode_d;
  logic [2:0]        hold_rdst_q, hold_rdst_d;
  logic [2:0]        hold_rsrc1_q, hold_rsrc1_d;
  logic [2:0]        hold_rsrc2_q, hold_rsrc2_d;
  logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;

  logic              valid_q, valid_d;
  logic [4:0]        opcode_q, opcode_d;
  logic [2:0]        rdst_q, rdst_d;
  logic [2:0]        rsrc1_q, rsrc1_d;
  logic [2:0]        rsrc2_q, rsrc2_d;
  logic              has_imm_q, has_imm_d;
  logic [15:0]       imm_q, imm_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;

  generate
    if (ADDR_W > 16) begin : g_boot_wide
      assign boot_pc = {{(ADDR_W-16){1'b0}}, imem_rdata};
    end else begin : g_boot_narrow
      assign boot_pc = imem_rdata[ADDR_W-1:0];
    end
  endgenerate

  assign imem_addr = (state_q == BOOT) ? BOOT_A : pc_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_opcode_d = hold_opcode_q;
    hold_rdst_d   = hold_rdst_q;
    hold_rsrc1_d  = hold_rsrc1_q;
    hold_rsrc2_d  = hold_rsrc2_q;
    hold_pc_d     = hold_pc_q;
    valid_d       = valid_q;
    opcode_d      = opcode_q;
    rdst_d        = rdst_q;
    rsrc1_d       = rsrc1_q;
    rsrc2_d       = rsrc2_q;
    has_imm_d     = has_imm_q;
    imm_d         = imm_q;
    if_pc_d       = if_pc_q;

    case (state_q)
      BOOT: begin
        pc_d    = boot_pc;
        state_d = FETCH;
      end
      FETCH, FETCH_IMM: begin
        if (branch_taken) begin
          pc_d    = branch_target;
          state_d = FETCH;
          valid_d = 1'b0;
        end else if (!stall) begin
          pc_d = pc_q + 1'b1;
          if (state_q == FETCH_IMM) begin
            opcode_d  = hold_opcode_q;
            rdst_d    = hold_rdst_q;
            rsrc1_d   = hold_rsrc1_q;
            rsrc2_d   = hold_rsrc2_q;
            has_imm_d = 1'b1;
            imm_d     = imem_rdata;
            if_pc_d   = hold_pc_q;
            valid_d   = 1'b1;
            state_d   = FETCH;
          end else if (imem_rdata[0]) begin
            hold_opcode_d = imem_rdata[15:11];
            hold_rdst_d   = imem_rdata[10:8];
            hold_rsrc1_d  = imem_rdata[7:5];
            hold_rsrc2_d  = imem_rdata[4:2];
            hold_pc_d     = pc_q;
            valid_d       = 1'b0;
            state_d       = FETCH_IMM;
          end else begin
            opcode_d  = imem_rdata[15:11];
            rdst_d    = imem_rdata[10:8];
            rsrc1_d   = imem_rdata[7:5];
            rsrc2_d   = imem_rdata[4:2];
            has_imm_d = 1'b0;
            imm_d     = 16'h0000;
            if_pc_d   = pc_q;
            valid_d   = 1'b1;
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= '0;
      hold_opcode_q <= '0;
      hold_rdst_q   <= '0;
      hold_rsrc1_q  <= '0;
      hold_rsrc2_q  <= '0;
      hold_pc_q     <= '0;
      valid_q       <= 1'b0;
      opcode_q      <= '0;
      rdst_q        <= '0;
      rsrc1_q       <= '0;
      rsrc2_q       <= '0;
      has_imm_q     <= 1'b0;
      imm_q         <= '0;
      if_pc_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      hold_opcode_q <= hold_opcode_d;
      hold_rdst_q   <= hold_rdst_d;
      hold_rsrc1_q  <= hold_rsrc1_d;
      hold_rsrc2_q  <= hold_rsrc2_d;
      hold_pc_q     <= hold_pc_d;
      valid_q       <= valid_d;
      opcode_q      <= opcode_d;
      rdst_q        <= rdst_d;
      rsrc1_q       <= rsrc1_d;
      rsrc2_q       <= rsrc2_d;
      has_imm_q     <= has_imm_d;
      imm_q         <= imm_d;
      if_pc_q       <= if_pc_d;
    end
  end

  assign if_valid   = valid_q;
  assign if_opcode  = opcode_q;
  assign if_rdst    = rdst_q;
  assign if_rsrc1   = rsrc1_q;
  assign if_rsrc2   = rsrc2_q;
  assign if_has_imm = has_imm_q;
  assign if_imm     = imm_q;
  assign if_pc      = if_pc_q;

endmodule

// File: tb/tb_fetch_issue_unit.sv
// tb/tb_fetch_issue_unit.sv - directed-vector bench for fetch_issue_unit (16-bit and 4-bit address builds)
module tb_fetch_issue_unit;

  logic clk;
  logic rst;
  logic stall;
  logic branch_taken;
  logic [15:0] branch_target;

  logic [15:0] imem_addr, imem_rdata;
  logic        if_valid, if_has_imm;
  logic [4:0]  if_opcode;
  logic [2:0]  if_rdst, if_rsrc1, if_rsrc2;
  logic [15:0] if_imm, if_pc;

  logic [3:0]  w_addr;
  logic [15:0] w_rdata;
  logic        w_valid, w_has_imm;
  logic [4:0]  w_opcode;
  logic [2:0]  w_rdst, w_rsrc1, w_rsrc2;
  logic [15:0] w_imm;
  logic [3:0]  w_pc;

  logic [15:0] mem  [0:255];
  logic [15:0] mem2 [0:15];

  int n_checks;
  int n_fail;

  assign imem_rdata = mem[imem_addr[7:0]];
  assign w_rdata    = mem2[w_addr];

  fetch_issue_unit #(.ADDR_W(16), .BOOT_ADDR(0)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .if_valid(if_valid), .if_opcode(if_opcode), .if_rdst(if_rdst),
    .if_rsrc1(if_rsrc1), .if_rsrc2(if_rsrc2), .if_has_imm(if_has_imm),
    .if_imm(if_imm), .if_pc(if_pc)
  );

  fetch_issue_unit #(.ADDR_W(4), .BOOT_ADDR(0)) dut_wrap (
    .clk(clk), .rst(rst), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .stall(1'b0), .branch_taken(1'b0), .branch_target(4'h0),
    .if_valid(w_valid), .if_opcode(w_opcode), .if_rdst(w_rdst),
    .if_rsrc1(w_rsrc1), .if_rsrc2(w_rsrc2), .if_has_imm(w_has_imm),
    .if_imm(w_imm), .if_pc(w_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 16; i++) mem2[i] = 16'h0000;
    mem[8'h00] = 16'h0010;
    mem[8'h10] = 16'h0A00;
    mem[8'h11] = 16'h1301;
    mem[8'h12] = 16'hBEEF;
    mem[8'h13] = 16'h2CA4;
    mem[8'h14] = 16'h3803;
    mem[8'h15] = 16'h1234;
    mem[8'h40] = 16'h4100;
    mem2[0]    = 16'h000F;
    mem2[15]   = 16'h0801;

    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
    tick(); tick();
    check("rst_valid", 32'(if_valid), 32'h0);
    check("rst_opcode", 32'(if_opcode), 32'h0);
    check("rst_imm", 32'(if_imm), 32'h0);
    check("rst_pc", 32'(if_pc), 32'h0);
    check("boot_addr", 32'(imem_addr), 32'h0);
    rst = 1'b0;

    tick();
    check("boot_valid", 32'(if_valid), 32'h0);
    check("boot_pc_load", 32'(imem_addr), 32'h10);
    check("wrap_boot_pc", 32'(w_addr), 32'hF);

    tick();
    check("s1_valid", 32'(if_valid), 32'h1);
    check("s1_opcode", 32'(if_opcode), 32'h1);
    check("s1_rdst", 32'(if_rdst), 32'h2);
    check("s1_has_imm", 32'(if_has_imm), 32'h0);
    check("s1_pc", 32'(if_pc), 32'h10);
    check("s1_addr", 32'(imem_addr), 32'h11);
    check("wrap_bubble_valid", 32'(w_valid), 32'h0);
    check("wrap_imm_addr", 32'(w_addr), 32'h0);

    tick();
    check("tw_bubble_valid", 32'(if_valid), 32'h0);
    check("tw_bubble_addr", 32'(imem_addr), 32'h12);
    check("wrap_valid", 32'(w_valid), 32'h1);
    check("wrap_opcode", 32'(w_opcode), 32'h1);
    check("wrap_has_imm", 32'(w_has_imm), 32'h1);
    check("wrap_imm", 32'(w_imm), 32'h000F);
    check("wrap_if_pc", 32'(w_pc), 32'hF);
    check("wrap_next_pc", 32'(w_addr), 32'h1);

    tick();
    check("tw_valid", 32'(if_valid), 32'h1);
    check("tw_opcode", 32'(if_opcode), 32'h2);
    check("tw_rdst", 32'(if_rdst), 32'h3);
    check("tw_has_imm", 32'(if_has_imm), 32'h1);
    check("tw_imm", 32'(if_imm), 32'hBEEF);
    check("tw_pc", 32'(if_pc), 32'h11);
    check("tw_next_addr", 32'(imem_addr), 32'h13);

    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall_valid", 32'(if_valid), 32'h1);
      check("stall_opcode", 32'(if_opcode), 32'h2);
      check("stall_imm", 32'(if_imm), 32'hBEEF);
      check("stall_pc", 32'(if_pc), 32'h11);
      check("stall_addr", 32'(imem_addr), 32'h13);
    end
    stall = 1'b0;

    tick();
    check("post_stall_valid", 32'(if_valid), 32'h1);
    check("post_stall_opcode", 32'(if_opcode), 32'h5);
    check("post_stall_rdst", 32'(if_rdst), 32'h4);
    check("post_stall_rsrc1", 32'(if_rsrc1), 32'h5);
    check("post_stall_rsrc2", 32'(if_rsrc2), 32'h1);
    check("post_stall_has_imm", 32'(if_has_imm), 32'h0);
    check("post_stall_imm", 32'(if_imm), 32'h0);
    check("post_stall_pc", 32'(if_pc), 32'h13);

    tick();
    check("no_dup_valid", 32'(if_valid), 32'h0);
    check("fimm_addr", 32'(imem_addr), 32'h15);

    branch_taken = 1'b1; branch_target = 16'h0040; stall = 1'b1;
    tick();
    branch_taken = 1'b0; stall = 1'b0;
    check("redir_valid", 32'(if_valid), 32'h0);
    check("redir_addr", 32'(imem_addr), 32'h40);
    check("redir_hold_opcode", 32'(if_opcode), 32'h5);

    tick();
    check("tgt_valid", 32'(if_valid), 32'h1);
    check("tgt_opcode", 32'(if_opcode), 32'h8);
    check("tgt_rdst", 32'(if_rdst), 32'h1);
    check("tgt_has_imm", 32'(if_has_imm), 32'h0);
    check("tgt_pc", 32'(if_pc), 32'h40);

    branch_taken = 1'b1; branch_target = 16'h0011;
    tick();
    branch_taken = 1'b0;
    check("redir2_addr", 32'(imem_addr), 32'h11);
    tick();
    check("arst_pre_addr", 32'(imem_addr), 32'h12);
    check("arst_pre_opcode", 32'(if_opcode), 32'h8);

    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(if_valid), 32'h0);
    check("arst_opcode", 32'(if_opcode), 32'h0);
    check("arst_imm", 32'(if_imm), 32'h0);
    check("arst_if_pc", 32'(if_pc), 32'h0);
    check("arst_addr", 32'(imem_addr), 32'h0);

    tick();
    rst = 1'b0;
    tick();
    check("reboot_addr", 32'(imem_addr), 32'h10);
    tick();
    check("reboot_valid", 32'(if_valid), 32'h1);
    check("reboot_opcode", 32'(if_opcode), 32'h1);
    check("reboot_pc", 32'(if_pc), 32'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
